// File: rtl/neotang_sdram_pkg.sv
// Shared types for the NeoTang SDRAM access path: arbiter FSM states,
// requester identifiers and byte-enable encodings.
package neotang_sdram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    RDWAIT = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    PORT_LD = 2'd0,
    PORT_A  = 2'd1,
    PORT_B  = 2'd2
  } arb_port_t;

  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_WORD = 2'b11;

  // Byte lane select for a byte write at the given byte-address LSB.
  function automatic logic [1:0] byte_be(input logic addr_lsb);
    return addr_lsb ? BE_HI : BE_LO;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Bundle of requester-side and controller-side signals around the SDRAM
// port arbiter. slave = arbiter view, master = requesters + controller view.
//
// Handshakes: a_rd/a_wr and b_rd/b_wr are request levels held until the
// matching x_ready pulse (one cycle, x_dout valid with it). ld_wr is a
// strobe that only counts in a cycle where ld_ready=1. mem_req is held with
// all mem_* stable until mem_ack; mem_rvalid/mem_rdata return read data
// any number of cycles after (or together with) mem_ack.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 25
) ();
  import neotang_sdram_pkg::*;

  logic              loading;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_data;
  logic              ld_wr;
  logic              ld_ready;

  logic [ADDR_W-1:0] a_addr;
  logic [15:0]       a_din;
  logic              a_rd;
  logic              a_wr;
  logic [15:0]       a_dout;
  logic              a_ready;

  logic [ADDR_W-1:0] b_addr;
  logic [15:0]       b_din;
  logic              b_rd;
  logic              b_wr;
  logic [15:0]       b_dout;
  logic              b_ready;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-2:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [1:0]        mem_be;
  logic              mem_ack;
  logic              mem_rvalid;
  logic [15:0]       mem_rdata;

  arb_state_t        dbg_state;

  modport slave (
    input  loading, ld_addr, ld_data, ld_wr,
    output ld_ready,
    input  a_addr, a_din, a_rd, a_wr,
    output a_dout, a_ready,
    input  b_addr, b_din, b_rd, b_wr,
    output b_dout, b_ready,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rvalid, mem_rdata,
    output dbg_state
  );

  modport master (
    output loading, ld_addr, ld_data, ld_wr,
    input  ld_ready,
    output a_addr, a_din, a_rd, a_wr,
    input  a_dout, a_ready,
    output b_addr, b_din, b_rd, b_wr,
    input  b_dout, b_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rvalid, mem_rdata,
    input  dbg_state
  );
endinterface

// File: rtl/sdram_arb_grant.sv
// Grant selection for the SDRAM port arbiter: loader exclusive while
// loading, otherwise B over A with a saturating starvation counter that
// forces A after STARVE_LIMIT consecutive B grants while A waits.
// With SDRAM_ARB_PERF_EN, also reports when an A grant was forced.
module sdram_arb_grant
  import neotang_sdram_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      i_eval,
  input  logic      i_loading,
  input  logic      i_ld_wr,
  input  logic      i_a_req,
  input  logic      i_b_req,
  output logic      o_valid,
  output arb_port_t o_port
`ifdef SDRAM_ARB_PERF_EN
  ,
  output logic      o_forced
`endif
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] r_starve_cnt;
  logic       w_forced;

  // Priority select: loader, then A if starved or alone, then B.
  always_comb begin
    o_valid  = 1'b0;
    o_port   = PORT_B;
    w_forced = 1'b0;
    if (i_loading) begin
      o_valid = i_ld_wr;
      o_port  = PORT_LD;
    end else if (i_a_req && (!i_b_req || (r_starve_cnt == LIMIT))) begin
      o_valid  = 1'b1;
      o_port   = PORT_A;
      w_forced = i_b_req;
    end else if (i_b_req) begin
      o_valid = 1'b1;
      o_port  = PORT_B;
    end
  end

`ifdef SDRAM_ARB_PERF_EN
  assign o_forced = w_forced;
`else
  logic w_unused_forced;
  assign w_unused_forced = w_forced;
`endif

  // Count B grants taken while A waits; clear when A is served or idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= 8'd0;
    end else if (!i_a_req) begin
      r_starve_cnt <= 8'd0;
    end else if (i_eval && o_valid && (o_port == PORT_A)) begin
      r_starve_cnt <= 8'd0;
    end else if (i_eval && o_valid && (o_port == PORT_B) && (r_starve_cnt != LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Three-way arbiter in front of the single-command SDRAM controller:
// ROM loader byte writes, core port A and core port B word accesses.
// One transaction in flight; IDLE -> CMD -> (RDWAIT) -> DONE -> IDLE.
// Optional macro SDRAM_ARB_PERF_EN adds per-port completion counters and a
// forced-A-grant counter.
module sdram_port_arbiter
  import neotang_sdram_pkg::*;
#(
  parameter int ADDR_W       = 25,
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  sdram_port_arbiter_if.slave bus
`ifdef SDRAM_ARB_PERF_EN
  ,
  output logic [31:0] perf_a_cnt,
  output logic [31:0] perf_b_cnt,
  output logic [31:0] perf_ld_cnt,
  output logic [31:0] perf_starve_cnt
`endif
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  arb_port_t         r_port;
  logic              r_we;
  logic [ADDR_W-2:0] r_addr;
  logic [15:0]       r_wdata;
  logic [1:0]        r_be;
  logic [15:0]       r_a_dout;
  logic [15:0]       r_b_dout;

  logic      w_idle;
  logic      w_a_req;
  logic      w_b_req;
  logic      w_gnt_valid;
  arb_port_t w_gnt_port;
  logic      w_take;
  logic      w_rd_cap;
  logic      w_mem_req;
  logic      w_ld_ready;
  logic      w_a_ready;
  logic      w_b_ready;
  logic      w_unused_addr;

  assign w_idle  = (r_state == IDLE);
  assign w_a_req = bus.a_rd | bus.a_wr;
  assign w_b_req = bus.b_rd | bus.b_wr;
  assign w_take  = w_idle & w_gnt_valid;

  // Read data is captured in RDWAIT, or in CMD when ack and rvalid coincide.
  assign w_rd_cap = bus.mem_rvalid &
                    ((r_state == RDWAIT) | ((r_state == CMD) & bus.mem_ack & ~r_we));

  // Word accesses ignore the byte-address LSB.
  assign w_unused_addr = bus.a_addr[0] ^ bus.b_addr[0];

`ifdef SDRAM_ARB_PERF_EN
  logic w_forced;
`endif

  sdram_arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk      (clk),
    .reset    (reset),
    .i_eval   (w_idle),
    .i_loading(bus.loading),
    .i_ld_wr  (bus.ld_wr),
    .i_a_req  (w_a_req),
    .i_b_req  (w_b_req),
    .o_valid  (w_gnt_valid),
    .o_port   (w_gnt_port)
`ifdef SDRAM_ARB_PERF_EN
    ,
    .o_forced (w_forced)
`endif
  );

  // FSM state register; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and state-decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_mem_req   = 1'b0;
    w_ld_ready  = 1'b0;
    w_a_ready   = 1'b0;
    w_b_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        w_ld_ready = bus.loading;
        if (w_gnt_valid) w_state_nxt = CMD;
      end
      CMD: begin
        w_mem_req = 1'b1;
        if (bus.mem_ack) w_state_nxt = (r_we || bus.mem_rvalid) ? DONE : RDWAIT;
      end
      RDWAIT: begin
        if (bus.mem_rvalid) w_state_nxt = DONE;
      end
      DONE: begin
        w_a_ready   = (r_port == PORT_A);
        w_b_ready   = (r_port == PORT_B);
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Latch the winning command so mem_* stay stable for the whole CMD phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_port  <= PORT_LD;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 16'd0;
      r_be    <= 2'b00;
    end else if (w_take) begin
      r_port <= w_gnt_port;
      case (w_gnt_port)
        PORT_LD: begin
          r_we    <= 1'b1;
          r_addr  <= bus.ld_addr[ADDR_W-1:1];
          r_wdata <= {bus.ld_data, bus.ld_data};
          r_be    <= byte_be(bus.ld_addr[0]);
        end
        PORT_A: begin
          r_we    <= bus.a_wr;
          r_addr  <= bus.a_addr[ADDR_W-1:1];
          r_wdata <= bus.a_din;
          r_be    <= BE_WORD;
        end
        default: begin
          r_we    <= bus.b_wr;
          r_addr  <= bus.b_addr[ADDR_W-1:1];
          r_wdata <= bus.b_din;
          r_be    <= BE_WORD;
        end
      endcase
    end
  end

  // Read data holding registers, one per core port.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_dout <= 16'd0;
      r_b_dout <= 16'd0;
    end else if (w_rd_cap) begin
      if (r_port == PORT_A) r_a_dout <= bus.mem_rdata;
      if (r_port == PORT_B) r_b_dout <= bus.mem_rdata;
    end
  end

`ifdef SDRAM_ARB_PERF_EN
  // Completion and forced-grant counters; free-running wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_a_cnt      <= 32'd0;
      perf_b_cnt      <= 32'd0;
      perf_ld_cnt     <= 32'd0;
      perf_starve_cnt <= 32'd0;
    end else begin
      if (r_state == DONE) begin
        case (r_port)
          PORT_A:  perf_a_cnt  <= perf_a_cnt + 32'd1;
          PORT_B:  perf_b_cnt  <= perf_b_cnt + 32'd1;
          default: perf_ld_cnt <= perf_ld_cnt + 32'd1;
        endcase
      end
      if (w_take && w_forced) perf_starve_cnt <= perf_starve_cnt + 32'd1;
    end
  end
`endif

  assign bus.ld_ready  = w_ld_ready;
  assign bus.a_ready   = w_a_ready;
  assign bus.b_ready   = w_b_ready;
  assign bus.a_dout    = r_a_dout;
  assign bus.b_dout    = r_b_dout;
  assign bus.mem_req   = w_mem_req;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_be    = r_be;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: behavioural SDRAM controller responder,
// command scoreboard and per-port read-data scoreboards.
module tb_sdram_port_arbiter;
  import neotang_sdram_pkg::*;

  localparam int ADDR_W = 25;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef SDRAM_ARB_PERF_EN
  logic [31:0] perf_a_cnt, perf_b_cnt, perf_ld_cnt, perf_starve_cnt;
`endif

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
`ifdef SDRAM_ARB_PERF_EN
    ,
    .perf_a_cnt     (perf_a_cnt),
    .perf_b_cnt     (perf_b_cnt),
    .perf_ld_cnt    (perf_ld_cnt),
    .perf_starve_cnt(perf_starve_cnt)
`endif
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [42:0] exp_q[$];   // {we, word addr, wdata, be}
  logic [16:0] a_q[$];     // {is_read, expected dout}
  logic [16:0] b_q[$];
  int   ack_dly     = 0;
  int   rv_dly      = 1;
  logic rd_fixed_en = 1'b0;
  logic [15:0] rd_fixed = 16'h0000;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rd_val(input logic [23:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC35A;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- controller model ----------------
  task automatic check_cmd();
    logic [42:0] e;
    if (exp_q.size() == 0) begin
      check_eq("cmd_unexp", 64'(exp_q.size()), 64'd1);
      return;
    end
    e = exp_q.pop_front();
    check_eq("cmd_we", 64'(bus.mem_we), 64'(e[42]));
    check_eq("cmd_addr", 64'(bus.mem_addr), 64'(e[41:18]));
    if (e[42]) begin
      check_eq("cmd_wdata", 64'(bus.mem_wdata), 64'(e[17:2]));
      check_eq("cmd_be", 64'(bus.mem_be), 64'(e[1:0]));
    end
  endtask

  initial begin : responder
    int wait_cnt;
    int rv_cnt;
    logic rv_pend;
    logic [15:0] rv_data;
    bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 16'h0;
    wait_cnt = 0; rv_cnt = 0; rv_pend = 1'b0; rv_data = 16'h0;
    forever begin
      tick();
      bus.mem_ack    = 1'b0;
      bus.mem_rvalid = 1'b0;
      if (rv_pend) begin
        if (rv_cnt <= 1) begin
          bus.mem_rvalid = 1'b1; bus.mem_rdata = rv_data; rv_pend = 1'b0;
        end else rv_cnt--;
      end
      if (bus.mem_req) begin
        if (wait_cnt >= ack_dly) begin
          bus.mem_ack = 1'b1;
          wait_cnt = 0;
          check_cmd();
          if (!bus.mem_we) begin
            rv_data = rd_fixed_en ? rd_fixed : rd_val(bus.mem_addr);
            if (rv_dly == 0) begin
              bus.mem_rvalid = 1'b1; bus.mem_rdata = rv_data;
            end else begin
              rv_pend = 1'b1; rv_cnt = rv_dly;
            end
          end
        end else wait_cnt++;
      end else wait_cnt = 0;
    end
  end

  // ---------------- completion monitor ----------------
  initial begin : ready_mon
    logic [16:0] e;
    forever begin
      tick();
      if (bus.a_ready) begin
        if (a_q.size() == 0) check_eq("a_ready_unexp", 64'(a_q.size()), 64'd1);
        else begin
          e = a_q.pop_front();
          if (e[16]) check_eq("a_dout", 64'(bus.a_dout), 64'(e[15:0]));
        end
      end
      if (bus.b_ready) begin
        if (b_q.size() == 0) check_eq("b_ready_unexp", 64'(b_q.size()), 64'd1);
        else begin
          e = b_q.pop_front();
          if (e[16]) check_eq("b_dout", 64'(bus.b_dout), 64'(e[15:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic port_req(input bit is_b, input bit rd, input bit wr,
                          input logic [24:0] addr, input logic [15:0] din);
    logic [15:0] rexp;
    int n;
    rexp = rd_fixed_en ? rd_fixed : rd_val(addr[24:1]);
    exp_q.push_back({wr, addr[24:1], din, BE_WORD});
    if (is_b) begin
      b_q.push_back({~wr, rexp});
      bus.b_addr = addr; bus.b_din = din; bus.b_rd = rd; bus.b_wr = wr;
    end else begin
      a_q.push_back({~wr, rexp});
      bus.a_addr = addr; bus.a_din = din; bus.a_rd = rd; bus.a_wr = wr;
    end
    n = 0;
    do begin
      tick(); n++;
    end while (!(is_b ? bus.b_ready : bus.a_ready) && n < 200);
    if (is_b) begin bus.b_rd = 1'b0; bus.b_wr = 1'b0; end
    else      begin bus.a_rd = 1'b0; bus.a_wr = 1'b0; end
  endtask

  task automatic ld_write(input logic [24:0] addr, input logic [7:0] data);
    int n;
    exp_q.push_back({1'b1, addr[24:1], data, data, (addr[0] ? 2'b10 : 2'b01)});
    n = 0;
    while (!bus.ld_ready && n < 200) begin tick(); n++; end
    bus.ld_addr = addr; bus.ld_data = data; bus.ld_wr = 1'b1;
    tick();
    bus.ld_wr = 1'b0;
  endtask

  task automatic wait_quiet(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() + a_q.size() + b_q.size()) != 0 && n < 500) begin tick(); n++; end
    tick(); tick();
    check_eq(tag, 64'(exp_q.size() + a_q.size() + b_q.size()), 64'd0);
  endtask

  task automatic chk_zero(input string p);
    check_eq({p, "_mem_req"},   64'(bus.mem_req),   64'd0);
    check_eq({p, "_mem_we"},    64'(bus.mem_we),    64'd0);
    check_eq({p, "_mem_addr"},  64'(bus.mem_addr),  64'd0);
    check_eq({p, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
    check_eq({p, "_mem_be"},    64'(bus.mem_be),    64'd0);
    check_eq({p, "_a_ready"},   64'(bus.a_ready),   64'd0);
    check_eq({p, "_b_ready"},   64'(bus.b_ready),   64'd0);
    check_eq({p, "_ld_ready"},  64'(bus.ld_ready),  64'd0);
    check_eq({p, "_a_dout"},    64'(bus.a_dout),    64'd0);
    check_eq({p, "_b_dout"},    64'(bus.b_dout),    64'd0);
    check_eq({p, "_state"},     64'(bus.dbg_state), 64'(IDLE));
  endtask

  // Hard stop if the sequence ever hangs.
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int n;
    int a_seen;
    bus.loading = 1'b0; bus.ld_addr = '0; bus.ld_data = 8'h0; bus.ld_wr = 1'b0;
    bus.a_addr = '0; bus.a_din = 16'h0; bus.a_rd = 1'b0; bus.a_wr = 1'b0;
    bus.b_addr = '0; bus.b_din = 16'h0; bus.b_rd = 1'b0; bus.b_wr = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    chk_zero("rst");
    reset = 1'b0;
    tick();
    chk_zero("post_rst");

    // Loader byte writes, odd and even lanes.
    bus.loading = 1'b1;
    tick();
    check_eq("ld_ready_idle", 64'(bus.ld_ready), 64'd1);
    ack_dly = 1;
    ld_write(25'h000003, 8'hA5);
    ld_write(25'h000010, 8'h3C);
    wait_quiet("t1_drain");
    bus.loading = 1'b0;
    tick();

    // Port A read with 5-cycle controller latency, then assorted word ops.
    ack_dly = 2; rv_dly = 5; rd_fixed_en = 1'b1; rd_fixed = 16'h1234;
    port_req(1'b0, 1'b1, 1'b0, 25'h100000, 16'h0000);
    check_eq("t3_a_dout", 64'(bus.a_dout), 64'h1234);
    rd_fixed_en = 1'b0;
    tick();
    check_eq("t3_a_ready_pulse", 64'(bus.a_ready), 64'd0);
    ack_dly = 0; rv_dly = 2;
    port_req(1'b0, 1'b0, 1'b1, 25'h0000A4, 16'hBEEF);
    port_req(1'b1, 1'b0, 1'b1, 25'h1F0002, 16'h4321);
    port_req(1'b1, 1'b1, 1'b1, 25'h0055AA, 16'h9A9A);
    rv_dly = 0;
    port_req(1'b1, 1'b1, 1'b0, 25'h012346, 16'h0000);
    wait_quiet("t3_drain");

    // Starvation guard: both held, expect B x8, A, B x8, A.
    ack_dly = 0; rv_dly = 1;
    for (int i = 0; i < 18; i++) begin
      if (i == 8 || i == 17) begin
        exp_q.push_back({1'b0, 24'h000100, 16'h0000, BE_WORD});
        a_q.push_back({1'b1, rd_val(24'h000100)});
      end else begin
        exp_q.push_back({1'b0, 24'h180200, 16'h0000, BE_WORD});
        b_q.push_back({1'b1, rd_val(24'h180200)});
      end
    end
    bus.a_addr = 25'h000200; bus.b_addr = 25'h300400;
    bus.a_rd = 1'b1; bus.b_rd = 1'b1;
    a_seen = 0; n = 0;
    while (a_seen < 2 && n < 2000) begin
      tick(); n++;
      if (bus.a_ready) a_seen++;
    end
    bus.a_rd = 1'b0; bus.b_rd = 1'b0;
    wait_quiet("t2_drain");

    // Loading rises while B read waits for data.
    ack_dly = 0; rv_dly = 4;
    exp_q.push_back({1'b0, 24'h010050, 16'h0000, BE_WORD});
    b_q.push_back({1'b1, rd_val(24'h010050)});
    bus.b_addr = 25'h0200A0; bus.b_rd = 1'b1;
    n = 0;
    while (bus.dbg_state != RDWAIT && n < 50) begin tick(); n++; end
    bus.loading = 1'b1;
    bus.a_addr = 25'h004444; bus.a_rd = 1'b1;
    tick();
    check_eq("t4_ld_ready_busy", 64'(bus.ld_ready), 64'd0);
    n = 0;
    while (!bus.b_ready && n < 50) begin tick(); n++; end
    bus.b_rd = 1'b0;
    ld_write(25'h000101, 8'h5E);
    ld_write(25'h000102, 8'h77);
    repeat (10) tick();
    check_eq("t4_ld_ready_stall", 64'(bus.ld_ready), 64'd1);
    check_eq("t4_no_req_stall", 64'(bus.mem_req), 64'd0);
    exp_q.push_back({1'b0, 24'h002222, 16'h0000, BE_WORD});
    a_q.push_back({1'b1, rd_val(24'h002222)});
    bus.loading = 1'b0;
    n = 0;
    while (!bus.a_ready && n < 50) begin tick(); n++; end
    bus.a_rd = 1'b0;
    wait_quiet("t4_drain");

    // Random single transactions.
    for (int k = 0; k < 20; k++) begin
      int op;
      bit sel_b;
      sel_b   = 1'($urandom_range(0, 1));
      op      = $urandom_range(0, 2);
      ack_dly = $urandom_range(0, 3);
      rv_dly  = $urandom_range(0, 6);
      port_req(sel_b, (op != 1), (op != 0), 25'($urandom), 16'($urandom));
    end
    wait_quiet("rnd_drain");

    // Reset while a read waits for data; late rvalid must be ignored.
    ack_dly = 0; rv_dly = 8;
    exp_q.push_back({1'b0, 24'h055E6F, 16'h0000, BE_WORD});
    a_q.push_back({1'b1, rd_val(24'h055E6F)});
    bus.a_addr = 25'h0ABCDE; bus.a_rd = 1'b1;
    n = 0;
    while (bus.dbg_state != RDWAIT && n < 50) begin tick(); n++; end
    reset = 1'b1;
    a_q.delete();
    bus.a_rd = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk_zero("t5_abort");
    repeat (10) tick();
    chk_zero("t5_late_rv");

`ifdef SDRAM_ARB_PERF_EN
    // Counters after a fresh reset: 3 A reads, 2 loader writes.
    reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
    ack_dly = 0; rv_dly = 1;
    for (int k = 0; k < 3; k++) port_req(1'b0, 1'b1, 1'b0, 25'(k * 2 + 25'h000600), 16'h0);
    bus.loading = 1'b1;
    tick();
    ld_write(25'h000020, 8'h11);
    ld_write(25'h000021, 8'h22);
    wait_quiet("t6_drain");
    bus.loading = 1'b0;
    tick();
    check_eq("t6_perf_a", 64'(perf_a_cnt), 64'd3);
    check_eq("t6_perf_ld", 64'(perf_ld_cnt), 64'd2);
    check_eq("t6_perf_b", 64'(perf_b_cnt), 64'd0);
    check_eq("t6_perf_starve", 64'(perf_starve_cnt), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
